// File: rtl/leaf_stream_packer_if.sv
// rtl/leaf_stream_packer_if.sv - user-side and BFT-side stream bundle for leaf_stream_packer
//
// Purpose: carries the per-channel user streams into the packer and the
//          single packet stream out toward the BFT.
// Signals:
//   din_user2packer  channel i payload at [i*PAYLOAD_BITS +: PAYLOAD_BITS]
//   vld_user2packer  per-channel valid
//   ack_packer2user  per-channel accept (at most one bit high)
//   dout_packer2bft  {valid, dest_leaf, dest_port, payload}
//   vld_packer2bft   packet valid
//   ack_bft2packer   downstream accept
// Modports: master = environment (users + BFT), slave = packer.
interface leaf_stream_packer_if #(
    parameter int NUM_IN_PORTS = 4,
    parameter int PAYLOAD_BITS = 32,
    parameter int PACKET_BITS  = 40
);
    logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0] din_user2packer;
    logic [NUM_IN_PORTS-1:0]              vld_user2packer;
    logic [NUM_IN_PORTS-1:0]              ack_packer2user;
    logic [PACKET_BITS-1:0]               dout_packer2bft;
    logic                                 vld_packer2bft;
    logic                                 ack_bft2packer;

    modport master (
        output din_user2packer, vld_user2packer, ack_bft2packer,
        input  ack_packer2user, dout_packer2bft, vld_packer2bft
    );

    modport slave (
        input  din_user2packer, vld_user2packer, ack_bft2packer,
        output ack_packer2user, dout_packer2bft, vld_packer2bft
    );
endinterface

// File: rtl/leaf_stream_packer.sv
// rtl/leaf_stream_packer.sv - N-channel round-robin packer with per-channel credits and destinations
//
// Purpose: merges NUM_IN_PORTS user streams into one packet stream toward the
//          BFT through a one-entry output register.
// Ports:
//   clk_user       sole clock, rising edge
//   reset          synchronous, active-high
//   bus            leaf_stream_packer_if.slave (user streams in, packet stream out)
//   cfg_*          destination leaf/port and enable write for one channel
//   credit_*       credit return for one channel
module leaf_stream_packer #(
    parameter int NUM_IN_PORTS  = 4,
    parameter int PAYLOAD_BITS  = 32,
    parameter int NUM_LEAF_BITS = 3,
    parameter int NUM_PORT_BITS = 4,
    parameter int CREDIT_BITS   = 8,
    parameter int INIT_CREDITS  = 64
) (
    input  logic                     clk_user,
    input  logic                     reset,
    leaf_stream_packer_if.slave      bus,
    input  logic                     cfg_wr,
    input  logic [NUM_PORT_BITS-1:0] cfg_chan,
    input  logic [NUM_LEAF_BITS-1:0] cfg_dest_leaf,
    input  logic [NUM_PORT_BITS-1:0] cfg_dest_port,
    input  logic                     cfg_enable,
    input  logic                     credit_vld,
    input  logic [NUM_PORT_BITS-1:0] credit_chan,
    input  logic [CREDIT_BITS-1:0]   credit_count
);
    localparam int PACKET_BITS = 1 + NUM_LEAF_BITS + NUM_PORT_BITS + PAYLOAD_BITS;

    logic [CREDIT_BITS-1:0]   r_credit    [NUM_IN_PORTS];
    logic [NUM_IN_PORTS-1:0]  r_enable;
    logic [NUM_LEAF_BITS-1:0] r_dest_leaf [NUM_IN_PORTS];
    logic [NUM_PORT_BITS-1:0] r_dest_port [NUM_IN_PORTS];
    logic [NUM_PORT_BITS-1:0] r_last_grant;
    logic [PACKET_BITS-1:0]   r_dout;
    logic                     r_vld;

    logic                     w_load_en;
    logic                     w_accept;
    logic [NUM_IN_PORTS-1:0]  w_eligible;
    logic [NUM_IN_PORTS-1:0]  w_grant;
    logic [NUM_PORT_BITS-1:0] w_grant_idx;
    logic [NUM_LEAF_BITS-1:0] w_sel_leaf;
    logic [NUM_PORT_BITS-1:0] w_sel_port;
    logic [PAYLOAD_BITS-1:0]  w_sel_payload;
    logic [CREDIT_BITS-1:0]   w_credit_next [NUM_IN_PORTS];

    assign w_load_en = !r_vld || bus.ack_bft2packer;
    // Reset masks the accept so nothing is acked or consumed in a reset cycle.
    assign w_accept  = w_load_en && (w_grant != '0) && !reset;

    assign bus.ack_packer2user = w_grant & {NUM_IN_PORTS{w_load_en && !reset}};
    assign bus.dout_packer2bft = r_dout;
    assign bus.vld_packer2bft  = r_vld;

    always_comb begin
        w_eligible = '0;
        for (int i = 0; i < NUM_IN_PORTS; i++) begin
            w_eligible[i] = bus.vld_user2packer[i] && r_enable[i] && (r_credit[i] != '0);
        end
    end

    // Walk candidates from farthest to nearest after last_grant; the last hit
    // assigned is therefore the nearest eligible channel in round-robin order.
    always_comb begin
        logic [NUM_PORT_BITS:0]  v_cand;
        logic [NUM_IN_PORTS-1:0] v_shift;
        w_grant = '0;
        v_cand  = '0;
        v_shift = '0;
        for (int k = NUM_IN_PORTS; k >= 1; k--) begin
            v_cand = {1'b0, r_last_grant} + (NUM_PORT_BITS+1)'(k);
            if (v_cand >= (NUM_PORT_BITS+1)'(NUM_IN_PORTS)) begin
                v_cand = v_cand - (NUM_PORT_BITS+1)'(NUM_IN_PORTS);
            end
            v_shift = w_eligible >> v_cand;
            if (v_shift[0]) begin
                w_grant = NUM_IN_PORTS'(1) << v_cand;
            end
        end
    end

    // One-hot grant, so OR-reduction acts as the select mux.
    always_comb begin
        w_grant_idx   = '0;
        w_sel_leaf    = '0;
        w_sel_port    = '0;
        w_sel_payload = '0;
        for (int i = 0; i < NUM_IN_PORTS; i++) begin
            if (w_grant[i]) begin
                w_grant_idx   = w_grant_idx   | NUM_PORT_BITS'(i);
                w_sel_leaf    = w_sel_leaf    | r_dest_leaf[i];
                w_sel_port    = w_sel_port    | r_dest_port[i];
                w_sel_payload = w_sel_payload | bus.din_user2packer[i*PAYLOAD_BITS +: PAYLOAD_BITS];
            end
        end
    end

    // Saturate the returned credits first, then take the accept decrement.
    // An accepting channel had credit >= 1, so the decrement cannot underflow.
    always_comb begin
        logic [CREDIT_BITS-1:0] v_add;
        logic [CREDIT_BITS:0]   v_sum;
        logic [CREDIT_BITS-1:0] v_sat;
        v_add = '0;
        v_sum = '0;
        v_sat = '0;
        for (int i = 0; i < NUM_IN_PORTS; i++) begin
            v_add = (credit_vld && credit_chan == NUM_PORT_BITS'(i)) ? credit_count : '0;
            v_sum = {1'b0, r_credit[i]} + {1'b0, v_add};
            v_sat = v_sum[CREDIT_BITS] ? '1 : v_sum[CREDIT_BITS-1:0];
            w_credit_next[i] = v_sat - CREDIT_BITS'(w_accept && w_grant[i]);
        end
    end

    always_ff @(posedge clk_user) begin
        if (reset) begin
            r_vld        <= 1'b0;
            r_dout       <= '0;
            r_last_grant <= NUM_PORT_BITS'(NUM_IN_PORTS - 1);
            r_enable     <= '0;
            for (int i = 0; i < NUM_IN_PORTS; i++) begin
                r_credit[i]    <= CREDIT_BITS'(INIT_CREDITS);
                r_dest_leaf[i] <= '0;
                r_dest_port[i] <= NUM_PORT_BITS'(i);
            end
        end else begin
            if (w_load_en) begin
                if (w_accept) begin
                    r_dout       <= {1'b1, w_sel_leaf, w_sel_port, w_sel_payload};
                    r_vld        <= 1'b1;
                    r_last_grant <= w_grant_idx;
                end else begin
                    // Only the valid bit is cleared; the rest of the word holds.
                    r_vld                 <= 1'b0;
                    r_dout[PACKET_BITS-1] <= 1'b0;
                end
            end
            for (int i = 0; i < NUM_IN_PORTS; i++) begin
                r_credit[i] <= w_credit_next[i];
                if (cfg_wr && cfg_chan == NUM_PORT_BITS'(i)) begin
                    r_dest_leaf[i] <= cfg_dest_leaf;
                    r_dest_port[i] <= cfg_dest_port;
                    r_enable[i]    <= cfg_enable;
                end
            end
        end
    end
endmodule

// File: tb/tb_leaf_stream_packer.sv
// tb/tb_leaf_stream_packer.sv - self-checking bench for leaf_stream_packer
module tb_leaf_stream_packer;
    localparam int N    = 4;
    localparam int PB   = 32;
    localparam int LB   = 3;
    localparam int PTB  = 4;
    localparam int CB   = 8;
    localparam int INIT = 2;
    localparam int PK   = 1 + LB + PTB + PB;
    localparam int CMAX = (1 << CB) - 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic           cfg_wr = 1'b0;
    logic [PTB-1:0] cfg_chan = '0;
    logic [LB-1:0]  cfg_dest_leaf = '0;
    logic [PTB-1:0] cfg_dest_port = '0;
    logic           cfg_enable = 1'b0;
    logic           credit_vld = 1'b0;
    logic [PTB-1:0] credit_chan = '0;
    logic [CB-1:0]  credit_count = '0;

    leaf_stream_packer_if #(.NUM_IN_PORTS(N), .PAYLOAD_BITS(PB), .PACKET_BITS(PK)) bus ();

    leaf_stream_packer #(
        .NUM_IN_PORTS(N), .PAYLOAD_BITS(PB), .NUM_LEAF_BITS(LB),
        .NUM_PORT_BITS(PTB), .CREDIT_BITS(CB), .INIT_CREDITS(INIT)
    ) dut (
        .clk_user(clk), .reset(reset), .bus(bus),
        .cfg_wr(cfg_wr), .cfg_chan(cfg_chan), .cfg_dest_leaf(cfg_dest_leaf),
        .cfg_dest_port(cfg_dest_port), .cfg_enable(cfg_enable),
        .credit_vld(credit_vld), .credit_chan(credit_chan), .credit_count(credit_count)
    );

    int checks = 0;
    int errors = 0;

    int            m_cred [N];
    bit            m_en   [N];
    int            m_leaf [N];
    int            m_port [N];
    int            m_last;
    bit            m_vld;
    logic [PK-1:0] m_dout;
    logic [N-1:0]  m_ack;
    bit            m_acc;
    int            m_idx;

    int grants[$];
    int ack_cnt [N];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_vld  = 1'b0;
        m_dout = '0;
        m_last = N - 1;
        for (int i = 0; i < N; i++) begin
            m_cred[i] = INIT;
            m_en[i]   = 1'b0;
            m_leaf[i] = 0;
            m_port[i] = i;
        end
    endfunction

    function automatic void model_comb();
        bit load;
        load  = !m_vld || bus.ack_bft2packer;
        m_acc = 1'b0;
        m_idx = 0;
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_last + k) % N;
            if (!m_acc && bus.vld_user2packer[c] && m_en[c] && m_cred[c] > 0) begin
                m_acc = 1'b1;
                m_idx = c;
            end
        end
        m_acc = m_acc && load && !reset;
        m_ack = m_acc ? (N'(1) << m_idx) : '0;
    endfunction

    function automatic void model_seq();
        int ch;
        if (reset) begin
            model_reset();
            return;
        end
        if (!m_vld || bus.ack_bft2packer) begin
            if (m_acc) begin
                m_dout = {1'b1, LB'(m_leaf[m_idx]), PTB'(m_port[m_idx]),
                          bus.din_user2packer[m_idx*PB +: PB]};
                m_vld  = 1'b1;
                m_last = m_idx;
            end else begin
                m_vld = 1'b0;
                m_dout[PK-1] = 1'b0;
            end
        end
        if (credit_vld && int'(credit_chan) < N) begin
            ch = int'(credit_chan);
            m_cred[ch] = (m_cred[ch] + int'(credit_count) > CMAX) ? CMAX : m_cred[ch] + int'(credit_count);
        end
        if (m_acc) m_cred[m_idx] = m_cred[m_idx] - 1;
        if (cfg_wr && int'(cfg_chan) < N) begin
            ch = int'(cfg_chan);
            m_leaf[ch] = int'(cfg_dest_leaf);
            m_port[ch] = int'(cfg_dest_port);
            m_en[ch]   = cfg_enable;
        end
    endfunction

    task automatic tick();
        @(negedge clk);
        model_comb();
        check("ack", 64'(bus.ack_packer2user), 64'(m_ack));
        check("vld", 64'(bus.vld_packer2bft), 64'(m_vld));
        check("dout", 64'(bus.dout_packer2bft), 64'(m_dout));
        for (int i = 0; i < N; i++) begin
            if (bus.ack_packer2user[i]) begin
                grants.push_back(i);
                ack_cnt[i]++;
            end
        end
        @(posedge clk);
        model_seq();
        #1;
    endtask

    task automatic do_cfg(input int ch, input int leaf, input int port, input bit en);
        cfg_wr = 1'b1; cfg_chan = PTB'(ch); cfg_dest_leaf = LB'(leaf);
        cfg_dest_port = PTB'(port); cfg_enable = en;
        tick();
        cfg_wr = 1'b0;
    endtask

    task automatic do_credit(input int ch, input int cnt);
        credit_vld = 1'b1; credit_chan = PTB'(ch); credit_count = CB'(cnt);
        tick();
        credit_vld = 1'b0;
    endtask

    task automatic clear_counts();
        grants.delete();
        for (int i = 0; i < N; i++) ack_cnt[i] = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [PK-1:0] held;
        int exp_g [8] = '{1, 2, 3, 0, 1, 2, 3, 0};

        bus.din_user2packer = '0;
        bus.vld_user2packer = '0;
        bus.ack_bft2packer  = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        model_reset();
        #1;
        tick();
        check("rst_vld", 64'(bus.vld_packer2bft), 64'd0);
        check("rst_dout", 64'(bus.dout_packer2bft), 64'd0);
        reset = 1'b0;

        // Single channel, same-cycle ack, one-cycle latency to dout.
        do_cfg(0, 5, 2, 1'b1);
        bus.din_user2packer[0 +: PB] = 32'hDEADBEEF;
        bus.vld_user2packer = 4'b0001;
        bus.ack_bft2packer  = 1'b1;
        #1;
        check("t1_ack", 64'(bus.ack_packer2user), 64'd1);
        tick();
        bus.vld_user2packer = '0;
        check("t1_dout", 64'(bus.dout_packer2bft), 64'hD2DEADBEEF);
        check("t1_vld", 64'(bus.vld_packer2bft), 64'd1);
        tick();

        // All four channels, round-robin continuing after last_grant=0.
        for (int i = 0; i < N; i++) do_credit(i, 100);
        do_cfg(1, 1, 9, 1'b1);
        do_cfg(2, 2, 10, 1'b1);
        do_cfg(3, 3, 11, 1'b1);
        for (int i = 0; i < N; i++) bus.din_user2packer[i*PB +: PB] = 32'hA0000000 + 32'(i);
        clear_counts();
        bus.vld_user2packer = 4'b1111;
        repeat (8) tick();
        check("t2_count", 64'(grants.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < grants.size()) check("t2_grant", 64'(grants[i]), 64'(exp_g[i]));
        end

        // Downstream stall: packet held, users not acked, then resume.
        held = bus.dout_packer2bft;
        bus.ack_bft2packer = 1'b0;
        repeat (5) begin
            #1;
            check("t3_ack_stall", 64'(bus.ack_packer2user), 64'd0);
            tick();
            check("t3_hold", 64'(bus.dout_packer2bft), 64'(held));
        end
        clear_counts();
        bus.ack_bft2packer = 1'b1;
        tick();
        check("t3_resume_n", 64'(grants.size()), 64'd1);
        if (grants.size() > 0) check("t3_resume_grant", 64'(grants[0]), 64'd1);
        bus.vld_user2packer = '0;
        tick();
        tick();

        // Credit exhaustion and return, then an out-of-range credit channel.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        do_cfg(1, 0, 1, 1'b1);
        clear_counts();
        bus.vld_user2packer = 4'b0010;
        repeat (5) tick();
        check("t4_init_credits", 64'(ack_cnt[1]), 64'd2);
        clear_counts();
        credit_vld = 1'b1; credit_chan = 4'd1; credit_count = 8'd3;
        #1;
        check("t4_zero_credit_ack", 64'(bus.ack_packer2user), 64'd0);
        tick();
        credit_vld = 1'b0;
        repeat (6) tick();
        check("t4_returned", 64'(ack_cnt[1]), 64'd3);
        do_credit(4, 5);
        clear_counts();
        repeat (3) tick();
        check("t4_bad_chan", 64'(ack_cnt[1]), 64'd0);
        bus.vld_user2packer = '0;

        // Saturation before decrement: 250 + 10 with a same-cycle accept.
        do_cfg(0, 1, 1, 1'b1);
        do_credit(0, 248);
        clear_counts();
        bus.vld_user2packer = 4'b0001;
        credit_vld = 1'b1; credit_chan = 4'd0; credit_count = 8'd10;
        tick();
        credit_vld = 1'b0;
        repeat (260) tick();
        check("t5_sat_total", 64'(ack_cnt[0]), 64'd255);
        bus.vld_user2packer = '0;
        tick();

        // Reset while a packet is held and users are valid.
        do_cfg(2, 4, 3, 1'b1);
        bus.vld_user2packer = 4'b0100;
        bus.ack_bft2packer  = 1'b0;
        tick();
        check("t6_held", 64'(bus.vld_packer2bft), 64'd1);
        bus.vld_user2packer = 4'b1111;
        reset = 1'b1;
        #1;
        check("t6_rst_ack", 64'(bus.ack_packer2user), 64'd0);
        tick();
        check("t6_rst_vld", 64'(bus.vld_packer2bft), 64'd0);
        check("t6_rst_dout", 64'(bus.dout_packer2bft), 64'd0);
        reset = 1'b0;
        bus.ack_bft2packer = 1'b1;
        clear_counts();
        repeat (3) tick();
        check("t6_disabled", 64'(ack_cnt[0] + ack_cnt[1] + ack_cnt[2] + ack_cnt[3]), 64'd0);
        do_cfg(2, 0, 2, 1'b1);
        clear_counts();
        repeat (4) tick();
        check("t6_init_credits", 64'(ack_cnt[2]), 64'd2);
        bus.vld_user2packer = '0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
